regfile_sb: RTL and testbench

Parametrised multi-read-port register file for the datapath, successor to the fixed 32x32 two-read-port file. It adds a configurable zero register, same-cycle write-to-read bypass, and a per-register busy scoreboard. Decode reserves a destination at issue and writeback releases it, so the hazard unit stalls on rd_busy. It also adds asynchronous reset, synchronous soft clear, and a reservation-conflict flag.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_scoreboard.sv | 61 ++++++
 rtl/regfile_sb.sv | 83 ++++++++
 tb/tb_regfile_sb.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEPTH      = 2 ** DEF_ADDR_W;

  // True when the address names the hardwired zero register.
  function automatic logic zero_hit(input bit zero_reg, input logic [31:0] addr);
    return zero_reg && (addr == 32'd0);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: reserve at issue, release at writeback, conflict pulse.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     soft_clr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rsv_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [NUM_REGS-1:0] busy;
  logic                rsv_legal;
  logic                rsv_conflict;

  always_comb begin
    rsv_legal    = rsv_en && !zero_hit(ZERO_REG, 32'(rsv_addr));
    rsv_conflict = rsv_legal && busy[rsv_addr] && !(wr_en && (wr_addr == rsv_addr));
  end

  // The reservation is assigned after the release so a same-address pair leaves the bit set.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      busy    <= '0;
      rsv_err <= 1'b0;
    end else if (soft_clr) begin
      busy    <= '0;
      rsv_err <= 1'b0;
    end else begin
      if (wr_en) begin
        busy[wr_addr] <= 1'b0;
      end
      if (rsv_legal) begin
        busy[rsv_addr] <= 1'b1;
      end
      rsv_err <= rsv_conflict;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [ADDR_W-1:0] addr;
    logic              released;

    assign addr     = rd_addr[g*ADDR_W +: ADDR_W];
    assign released = BYPASS && wr_en && (wr_addr == addr);
    assign rd_busy[g] = !zero_hit(ZERO_REG, 32'(addr)) && busy[addr] && !released;
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with zero register, write bypass and busy scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr_n,
  input  logic                     soft_clr,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  output logic                     rsv_err
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_live;

  assign wr_live = wr_en && !zero_hit(ZERO_REG, 32'(wr_addr));

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else if (soft_clr) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_live) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Zero register beats bypass, which beats the stored value.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_read
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] port_data;

    assign addr = rd_addr[g*ADDR_W +: ADDR_W];

    always_comb begin
      port_data = mem[addr];
      if (zero_hit(ZERO_REG, 32'(addr))) begin
        port_data = '0;
      end else if (BYPASS && wr_en && (wr_addr == addr)) begin
        port_data = wr_data;
      end
    end

    assign rd_data[g*DATA_W +: DATA_W] = port_data;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .NUM_RD  (NUM_RD),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_scoreboard (
    .clk     (clk),
    .clr_n   (clr_n),
    .soft_clr(soft_clr),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .rsv_en  (rsv_en),
    .rsv_addr(rsv_addr),
    .rd_addr (rd_addr),
    .rd_busy (rd_busy),
    .rsv_err (rsv_err)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench: vector table, corner sequences and a randomized reference model.
module tb_regfile_sb;

  logic        clk;
  logic        clr_n;
  logic        soft_clr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        rsv_err, rsv_err_nb;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        sc;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic        e;
  } vec_t;

  vec_t vq[$];

  logic [31:0] mem_m [32];
  logic        busy_m [32];
  logic        err_m;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
    .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_busy(rd_busy), .rsv_err(rsv_err)
  );

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .clr_n(clr_n), .soft_clr(soft_clr), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rsv_en(rsv_en), .rsv_addr(rsv_addr), .rd_addr(rd_addr),
    .rd_data(rd_data_nb), .rd_busy(rd_busy_nb), .rsv_err(rsv_err_nb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: architectural register contents plus a set of outstanding producers.
  function automatic logic [31:0] model_read(input bit bp, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (bp && wr_en && wr_addr == a) return wr_data;
    return mem_m[a];
  endfunction

  function automatic logic model_busy(input bit bp, input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (bp && wr_en && wr_addr == a) return 1'b0;
    return busy_m[a];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mem_m[r]  = 32'd0;
      busy_m[r] = 1'b0;
    end
    err_m = 1'b0;
  endtask

  task automatic model_edge();
    logic err_n;
    if (soft_clr) begin
      model_reset();
    end else begin
      err_n = rsv_en && rsv_addr != 5'd0 && busy_m[rsv_addr] &&
              !(wr_en && wr_addr == rsv_addr);
      if (wr_en && wr_addr != 5'd0) mem_m[wr_addr] = wr_data;
      if (wr_en) busy_m[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 5'd0) busy_m[rsv_addr] = 1'b1;
      err_m = err_n;
    end
  endtask

  task automatic check_model();
    logic [4:0] a;
    for (int p = 0; p < 2; p++) begin
      a = rd_addr[p*5 +: 5];
      check($sformatf("model_data_p%0d", p), rd_data[p*32 +: 32], model_read(1'b1, a));
      check($sformatf("model_data_nb_p%0d", p), rd_data_nb[p*32 +: 32], model_read(1'b0, a));
      check($sformatf("model_busy_p%0d", p), 32'(rd_busy[p]), 32'(model_busy(1'b1, a)));
      check($sformatf("model_busy_nb_p%0d", p), 32'(rd_busy_nb[p]), 32'(model_busy(1'b0, a)));
    end
    check("model_err", 32'(rsv_err), 32'(err_m));
    check("model_err_nb", 32'(rsv_err_nb), 32'(err_m));
  endtask

  task automatic set_idle(input logic [4:0] a0, input logic [4:0] a1);
    soft_clr = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = 5'd0;
    wr_data  = 32'd0;
    rsv_en   = 1'b0;
    rsv_addr = 5'd0;
    rd_addr  = {a1, a0};
  endtask

  task automatic apply_stimulus(input vec_t v);
    soft_clr = v.sc;
    wr_en    = v.we;
    wr_addr  = v.wa;
    wr_data  = v.wd;
    rsv_en   = v.re;
    rsv_addr = v.ra;
    rd_addr  = {v.a1, v.a0};
  endtask

  task automatic check_output(input vec_t v, input int idx);
    check($sformatf("v%0d_data0", idx), rd_data[31:0], v.d0);
    check($sformatf("v%0d_data1", idx), rd_data[63:32], v.d1);
    check($sformatf("v%0d_busy", idx), 32'(rd_busy), 32'(v.b));
    check($sformatf("v%0d_err", idx), 32'(rsv_err), 32'(v.e));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    vec_t v;
    clr_n = 1'b0;
    set_idle(5'd5, 5'd31);
    model_reset();
    #3;
    check("reset_data0", rd_data[31:0], 32'd0);
    check("reset_data1", rd_data[63:32], 32'd0);
    check("reset_busy", 32'(rd_busy), 32'd0);
    check("reset_err", 32'(rsv_err), 32'd0);
    #9 clr_n = 1'b1;
    @(posedge clk);
    #1;

    //             sc    we    wa     wd             re    ra     a0     a1     d0             d1             b      e
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  5'd31, 32'h0,         32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b1, 5'd3,  32'h12345678,  1'b0, 5'd0,  5'd3,  5'd3,  32'h12345678,  32'h12345678,  2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd3,  5'd0,  32'h12345678,  32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF,  1'b0, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd0,  5'd0,  5'd0,  32'h0,         32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd0,  5'd3,  32'h0,         32'h12345678,  2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd9,  5'd9,  5'd9,  32'h0,         32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd3,  32'h0,         32'h12345678,  2'b01, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd3,  5'd9,  32'h12345678,  32'h0,         2'b10, 1'b0});
    vq.push_back('{1'b0, 1'b1, 5'd9,  32'hA5,        1'b0, 5'd0,  5'd9,  5'd9,  32'hA5,        32'hA5,        2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd9,  5'd9,  32'hA5,        32'hA5,        2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b1, 5'd4,  32'h1,         1'b1, 5'd4,  5'd4,  5'd9,  32'h1,         32'hA5,        2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd4,  5'd4,  32'h1,         32'h1,         2'b11, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd4,  5'd4,  5'd4,  32'h1,         32'h1,         2'b11, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd4,  5'd4,  32'h1,         32'h1,         2'b11, 1'b1});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd4,  5'd4,  32'h1,         32'h1,         2'b11, 1'b0});
    vq.push_back('{1'b0, 1'b1, 5'd4,  32'h2,         1'b1, 5'd4,  5'd4,  5'd4,  32'h2,         32'h2,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd4,  5'd4,  32'h2,         32'h2,         2'b11, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd1,  5'd1,  5'd2,  32'h0,         32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b1, 5'd2,  5'd1,  5'd2,  32'h0,         32'h0,         2'b01, 1'b0});
    vq.push_back('{1'b0, 1'b1, 5'd1,  32'h55,        1'b1, 5'd1,  5'd1,  5'd2,  32'h55,        32'h0,         2'b10, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd1,  5'd2,  32'h55,        32'h0,         2'b11, 1'b0});
    vq.push_back('{1'b1, 1'b1, 5'd2,  32'h77,        1'b1, 5'd5,  5'd1,  5'd2,  32'h55,        32'h77,        2'b01, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd1,  5'd2,  32'h0,         32'h0,         2'b00, 1'b0});
    vq.push_back('{1'b0, 1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd4,  5'd5,  32'h0,         32'h0,         2'b00, 1'b0});

    foreach (vq[i]) begin
      v = vq[i];
      apply_stimulus(v);
      #3;
      check_output(v, i);
      check_model();
      tick();
    end

    // Without bypass the writeback is invisible until the edge and busy persists in that cycle.
    set_idle(5'd6, 5'd6);
    rsv_en = 1'b1; rsv_addr = 5'd6;
    #3 check_model();
    tick();
    set_idle(5'd6, 5'd6);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h12345678;
    #3;
    check("nb_same_cycle_data", rd_data_nb[31:0], 32'h0);
    check("nb_same_cycle_busy", 32'(rd_busy_nb), 32'd3);
    check("bp_same_cycle_data", rd_data[31:0], 32'h12345678);
    check("bp_same_cycle_busy", 32'(rd_busy), 32'd0);
    check_model();
    tick();
    set_idle(5'd6, 5'd6);
    #3;
    check("nb_next_cycle_data", rd_data_nb[63:32], 32'h12345678);
    check("nb_next_cycle_busy", 32'(rd_busy_nb), 32'd0);
    tick();

    // Asynchronous reset in the middle of a write, with r7 previously written and reserved.
    set_idle(5'd7, 5'd7);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h11;
    tick();
    set_idle(5'd7, 5'd7);
    rsv_en = 1'b1; rsv_addr = 5'd7;
    tick();
    set_idle(5'd7, 5'd7);
    #3 check("r7_busy_before_reset", 32'(rd_busy), 32'd3);
    tick();
    set_idle(5'd7, 5'd7);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEADBEEF;
    #2 clr_n = 1'b0;
    @(posedge clk);
    #1;
    set_idle(5'd7, 5'd7);
    model_reset();
    #2 clr_n = 1'b1;
    #1;
    check("post_reset_r7", rd_data[31:0], 32'h0);
    check("post_reset_r7_nb", rd_data_nb[63:32], 32'h0);
    check("post_reset_busy", 32'(rd_busy), 32'd0);
    check("post_reset_err", 32'(rsv_err), 32'd0);
    tick();

    // Random traffic over a small address window so hazards collide often.
    for (int c = 0; c < 600; c++) begin
      soft_clr = ($urandom_range(0, 63) == 0);
      wr_en    = 1'($urandom_range(0, 1));
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      wr_data  = $urandom;
      rsv_en   = 1'($urandom_range(0, 1));
      rsv_addr = 5'($urandom_range(0, 7));
      rd_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #3 check_model();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
